fluxo_dados_gen: RTL and testbench
==================================

# fluxo_dados_gen

Parametrised datapath for the sequence-memory game: holds the target sequence in an internal writable memory instead of fixed ROMs, supports externally loaded or LFSR-generated sequences, a programmable game length and a saturating score. It sits under the game FSM (unidade de controle), which drives every zera/conta/registra strobe and consumes the status flags. All state is synchronous to one clock.

## Interface
- CHANNELS, 4: number of buttons/LEDs; width of a jogada.
- DEPTH, 16: maximum sequence length; AW = $clog2(DEPTH).
- LED_TIME, 1000: LED display timer period, in cycles.
- TIMEOUT, 5000: jogada timeout period, in cycles.
- SEED, 16'hACE1: LFSR reset value; must be nonzero.

- clock  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high; overrides every other input.
- zeraC, contaC  in  1  clear/increment the jogada address counter (AW bits).
- zeraS, contaS  in  1  clear/increment the sequence-length counter (AW bits).
- zeraR, registraR  in  1  clear/load the jogada register from chaves.
- chaves  in  CHANNELS  player buttons.
- zeraD, registraD  in  1  clear/load the limite register.
- limite_in  in  AW  last valid sequence index (game length - 1).
- modo  in  1  0 = loaded sequence, 1 = random sequence; sampled by registraD.
- gera  in  1  in random mode, write a one-hot LFSR entry at address contadorS.
- load_we  in  1  external memory write strobe.
- load_addr  in  AW  external write address.
- load_data  in  CHANNELS  external write data.
- zeraT, contaT  in  1  timeout counter control.
- zeraTLeds, contaTLeds  in  1  LED timer control.
- zeraM, registraM  in  1  clear/load the LED register.
- zeraP, incPontos  in  1  clear/increment the score.
- leds  out  CHANNELS  LED register.
- igual  out  1  mem[contadorC] == jogada register.
- fimS  out  1  contadorC == contadorS.
- fimJ  out  1  contadorS == limite.
- fimT  out  1  timeout counter == TIMEOUT-1.
- timerLedsFim  out  1  LED timer == LED_TIME-1.
- jogada_feita  out  1  one-cycle pulse on a rising edge of the OR of chaves.
- jogada_valida  out  1  chaves has exactly one bit set.
- pontos  out  AW+1  score.
- db_contagem, db_seqCont  out  AW  counter values.
- db_memoria, db_jogada  out  CHANNELS  mem[contadorC] and the jogada register.

## Operation
- Counters are synchronous. Priority: reset > zera > conta. contadorC and contadorS wrap from DEPTH-1 to 0.
- Timer counters wrap from period-1 to 0. Their fim flags are combinational decodes of the count.
- Memory is a DEPTH x CHANNELS register array:
  - Write is synchronous.
  - Read at contadorC is combinational and feeds igual, db_memoria and the LED register input.
  - Contents are not cleared by reset.
- Write port priority:
  - gera (only when the registered modo = 1) writes onehot(lfsr[7:0] % CHANNELS) at contadorS.
  - Otherwise load_we writes load_data at load_addr.
  - gera is ignored when modo = 0. If gera and load_we are asserted together in random mode, load_we is dropped.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Resets to SEED and advances every cycle regardless of other inputs.
- LED register:
  - Cleared on reset, zeraM, or when the LED timer equals LED_TIME/2 (half-period blank).
  - Otherwise loads mem[contadorC] on registraM. Clear beats load.
- jogada_feita: registered prev = |chaves (reset to 1). Output pulse = |chaves & ~prev, combinational, so it asserts in the same cycle chaves first becomes nonzero.
- jogada_valida: combinational popcount(chaves) == 1.
- pontos: zeraP clears it. incPontos adds 1, saturating at DEPTH; further incPontos holds the value.
- limite and modo registers reset to DEPTH-1 and 0.

## Timing
- Reset values:
  - Counters, leds, pontos, jogada register = 0.
  - limite = DEPTH-1, modo = 0.
  - Therefore igual reflects mem[0] == 0, fimS = 1, fimJ = 0 (1 if DEPTH = 1), fimT = 0, timerLedsFim = 0, jogada_feita = 0.
- Every registered output updates on the edge where its strobe is sampled high and is visible the next cycle.
- Status flags are combinational from registered state, so they have zero added latency.
- A memory write at cycle n is visible on igual/db_memoria at cycle n+1.
- Reset mid-game: all counters, timers and registers return to their reset values in one cycle. Memory is preserved, so a loaded sequence survives a restart.

## Test plan
- Reset, then load mem[0..2] = 1, 2, 4; chaves = 2, registraR, contaC -> at contadorC = 1, igual = 1, fimS = 0; after contaS x1, fimS = 1.
- limite_in = 3, registraD; contaS x3 -> fimJ = 1 exactly when db_seqCont = 3. contaS x13 more -> counter wraps to 0.
- modo = 1, gera with contaS over 16 cycles -> every memory word is one-hot (popcount 1) and < 16. load_we asserted in the same cycles -> the gera value is stored.
- contaTLeds held with registraM pulsed at start, mem[0] = 8 -> leds = 8, cleared at count 500, timerLedsFim high at count 999 for one cycle.
- chaves 0 -> 4 held for 3 cycles -> jogada_feita high only in the first cycle, jogada_valida = 1. chaves = 6 -> jogada_valida = 0.
- incPontos held for 20 cycles with DEPTH = 16 -> pontos saturates at 16. contaT held for 5000 cycles -> fimT pulses at cycle 4999. Synchronous reset in the next cycle -> all counts 0.

Source files
------------

// File: rtl/fluxo_dados_gen.sv
// ---------------------------------------------------------------------------
// fluxo_dados_gen -- datapath for the sequence-memory game.
//
// Holds the target sequence in a writable DEPTH x CHANNELS register array.
// The array is filled either from an external load port or, in random mode,
// with one-hot words derived from a free-running 16-bit LFSR. The block also
// provides a programmable game length (limite), a saturating score, the LED
// register with its display timer, and a jogada timeout timer. Every
// zera/conta/registra strobe comes from the game FSM, which reads back the
// status flags.
//
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   zeraC/contaC            jogada address counter (contadorC)
//   zeraS/contaS            sequence-length counter (contadorS)
//   zeraR/registraR         jogada register <- chaves
//   zeraD/registraD         limite <- limite_in, modo <- modo
//   gera                    random mode: write LFSR one-hot word at contadorS
//   load_we/addr/data       external memory write port
//   zeraT/contaT            timeout timer        -> fimT
//   zeraTLeds/contaTLeds    LED display timer    -> timerLedsFim
//   zeraM/registraM         LED register <- mem[contadorC]
//   zeraP/incPontos         saturating score     -> pontos
//   leds, igual, fimS, fimJ, jogada_feita, jogada_valida, db_*  status/debug
// ---------------------------------------------------------------------------
module fluxo_dados_gen #(
    parameter int          CHANNELS = 4,
    parameter int          DEPTH    = 16,
    parameter int          LED_TIME = 1000,
    parameter int          TIMEOUT  = 5000,
    parameter logic [15:0] SEED     = 16'hACE1,
    parameter int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                zeraC,
    input  logic                contaC,
    input  logic                zeraS,
    input  logic                contaS,
    input  logic                zeraR,
    input  logic                registraR,
    input  logic [CHANNELS-1:0] chaves,
    input  logic                zeraD,
    input  logic                registraD,
    input  logic [AW-1:0]       limite_in,
    input  logic                modo,
    input  logic                gera,
    input  logic                load_we,
    input  logic [AW-1:0]       load_addr,
    input  logic [CHANNELS-1:0] load_data,
    input  logic                zeraT,
    input  logic                contaT,
    input  logic                zeraTLeds,
    input  logic                contaTLeds,
    input  logic                zeraM,
    input  logic                registraM,
    input  logic                zeraP,
    input  logic                incPontos,
    output logic [CHANNELS-1:0] leds,
    output logic                igual,
    output logic                fimS,
    output logic                fimJ,
    output logic                fimT,
    output logic                timerLedsFim,
    output logic                jogada_feita,
    output logic                jogada_valida,
    output logic [AW:0]         pontos,
    output logic [AW-1:0]       db_contagem,
    output logic [AW-1:0]       db_seqCont,
    output logic [CHANNELS-1:0] db_memoria,
    output logic [CHANNELS-1:0] db_jogada
);

    localparam int PW = AW + 1;
    localparam int LW = (LED_TIME > 1) ? $clog2(LED_TIME) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CHANNELS-1:0] mem_q [DEPTH];

    logic [AW-1:0]       cnt_c_q, cnt_c_d;
    logic [AW-1:0]       cnt_s_q, cnt_s_d;
    logic [AW-1:0]       limite_q, limite_d;
    logic                modo_q, modo_d;
    logic [CHANNELS-1:0] jog_q, jog_d;
    logic [CHANNELS-1:0] leds_q, leds_d;
    logic [LW-1:0]       tled_q, tled_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic [PW-1:0]       pontos_q, pontos_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic                prev_q, prev_d;

    logic                mem_we;
    logic [AW-1:0]       mem_waddr;
    logic [CHANNELS-1:0] mem_wdata;
    logic [CHANNELS-1:0] mem_rdata;
    logic [7:0]          gera_idx;
    logic                any_chave;

    assign mem_rdata = mem_q[cnt_c_q];
    assign any_chave = |chaves;
    assign gera_idx  = lfsr_q[7:0] % 8'(CHANNELS);

    // Write port arbitration: an LFSR write in random mode wins over the
    // external load port; gera has no effect while the registered modo is 0.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = load_addr;
        mem_wdata = load_data;
        if (gera && modo_q) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_s_q;
            mem_wdata = CHANNELS'(1) << gera_idx;
        end else if (load_we) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        cnt_c_d = cnt_c_q;
        if (zeraC) begin
            cnt_c_d = '0;
        end else if (contaC) begin
            cnt_c_d = (cnt_c_q == AW'(DEPTH - 1)) ? '0 : cnt_c_q + AW'(1);
        end

        cnt_s_d = cnt_s_q;
        if (zeraS) begin
            cnt_s_d = '0;
        end else if (contaS) begin
            cnt_s_d = (cnt_s_q == AW'(DEPTH - 1)) ? '0 : cnt_s_q + AW'(1);
        end

        jog_d = jog_q;
        if (zeraR) begin
            jog_d = '0;
        end else if (registraR) begin
            jog_d = chaves;
        end

        limite_d = limite_q;
        modo_d   = modo_q;
        if (zeraD) begin
            limite_d = '0;
            modo_d   = 1'b0;
        end else if (registraD) begin
            limite_d = limite_in;
            modo_d   = modo;
        end

        tled_d = tled_q;
        if (zeraTLeds) begin
            tled_d = '0;
        end else if (contaTLeds) begin
            tled_d = (tled_q == LW'(LED_TIME - 1)) ? '0 : tled_q + LW'(1);
        end

        tmo_d = tmo_q;
        if (zeraT) begin
            tmo_d = '0;
        end else if (contaT) begin
            tmo_d = (tmo_q == TW'(TIMEOUT - 1)) ? '0 : tmo_q + TW'(1);
        end

        // Blank the LEDs for the second half of each display period.
        leds_d = leds_q;
        if (zeraM || (tled_q == LW'(LED_TIME / 2))) begin
            leds_d = '0;
        end else if (registraM) begin
            leds_d = mem_rdata;
        end

        pontos_d = pontos_q;
        if (zeraP) begin
            pontos_d = '0;
        end else if (incPontos && (pontos_q != PW'(DEPTH))) begin
            pontos_d = pontos_q + PW'(1);
        end

        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        prev_d = any_chave;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_c_q  <= '0;
            cnt_s_q  <= '0;
            jog_q    <= '0;
            limite_q <= AW'(DEPTH - 1);
            modo_q   <= 1'b0;
            tled_q   <= '0;
            tmo_q    <= '0;
            leds_q   <= '0;
            pontos_q <= '0;
            lfsr_q   <= SEED;
            prev_q   <= 1'b1;
        end else begin
            cnt_c_q  <= cnt_c_d;
            cnt_s_q  <= cnt_s_d;
            jog_q    <= jog_d;
            limite_q <= limite_d;
            modo_q   <= modo_d;
            tled_q   <= tled_d;
            tmo_q    <= tmo_d;
            leds_q   <= leds_d;
            pontos_q <= pontos_d;
            lfsr_q   <= lfsr_d;
            prev_q   <= prev_d;
        end
    end

    assign leds          = leds_q;
    assign igual         = (mem_rdata == jog_q);
    assign fimS          = (cnt_c_q == cnt_s_q);
    assign fimJ          = (cnt_s_q == limite_q);
    assign fimT          = (tmo_q == TW'(TIMEOUT - 1));
    assign timerLedsFim  = (tled_q == LW'(LED_TIME - 1));
    assign jogada_feita  = any_chave & ~prev_q;
    assign jogada_valida = ($countones(chaves) == 1);
    assign pontos        = pontos_q;
    assign db_contagem   = cnt_c_q;
    assign db_seqCont    = cnt_s_q;
    assign db_memoria    = mem_rdata;
    assign db_jogada     = jog_q;

endmodule

// File: tb/tb_fluxo_dados_gen.sv
// ---------------------------------------------------------------------------
// Self-checking bench for fluxo_dados_gen (default parameters: 4 channels,
// depth 16, LED period 1000, timeout 5000). Expected values come from plain
// integer models of the counters, memory contents, score and timers.
// ---------------------------------------------------------------------------
module tb_fluxo_dados_gen;

    logic       clock = 1'b0;
    logic       reset;
    logic       zeraC, contaC, zeraS, contaS, zeraR, registraR;
    logic [3:0] chaves;
    logic       zeraD, registraD;
    logic [3:0] limite_in;
    logic       modo, gera, load_we;
    logic [3:0] load_addr, load_data;
    logic       zeraT, contaT, zeraTLeds, contaTLeds, zeraM, registraM;
    logic       zeraP, incPontos;
    logic [3:0] leds;
    logic       igual, fimS, fimJ, fimT, timerLedsFim, jogada_feita, jogada_valida;
    logic [4:0] pontos;
    logic [3:0] db_contagem, db_seqCont, db_memoria, db_jogada;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         c_m, s_m, t_m, p_m;
    logic [3:0] mem_m [16];

    fluxo_dados_gen #(
        .CHANNELS(4), .DEPTH(16), .LED_TIME(1000), .TIMEOUT(5000), .SEED(16'hACE1)
    ) dut (
        .clock(clock), .reset(reset),
        .zeraC(zeraC), .contaC(contaC), .zeraS(zeraS), .contaS(contaS),
        .zeraR(zeraR), .registraR(registraR), .chaves(chaves),
        .zeraD(zeraD), .registraD(registraD), .limite_in(limite_in), .modo(modo),
        .gera(gera), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .zeraT(zeraT), .contaT(contaT), .zeraTLeds(zeraTLeds), .contaTLeds(contaTLeds),
        .zeraM(zeraM), .registraM(registraM), .zeraP(zeraP), .incPontos(incPontos),
        .leds(leds), .igual(igual), .fimS(fimS), .fimJ(fimJ), .fimT(fimT),
        .timerLedsFim(timerLedsFim), .jogada_feita(jogada_feita),
        .jogada_valida(jogada_valida), .pontos(pontos),
        .db_contagem(db_contagem), .db_seqCont(db_seqCont),
        .db_memoria(db_memoria), .db_jogada(db_jogada)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        reset = 0; zeraC = 0; contaC = 0; zeraS = 0; contaS = 0; zeraR = 0; registraR = 0;
        chaves = 0; zeraD = 0; registraD = 0; limite_in = 0; modo = 0; gera = 0;
        load_we = 0; load_addr = 0; load_data = 0; zeraT = 0; contaT = 0;
        zeraTLeds = 0; contaTLeds = 0; zeraM = 0; registraM = 0; zeraP = 0; incPontos = 0;
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        step();
        reset = 0;
        c_m = 0; s_m = 0;
        checks++; if (db_contagem !== 4'd0) begin errors++; $display("FAIL reset_contC: got %0d expected 0", db_contagem); end
        checks++; if (db_seqCont !== 4'd0) begin errors++; $display("FAIL reset_contS: got %0d expected 0", db_seqCont); end
        checks++; if (leds !== 4'd0) begin errors++; $display("FAIL reset_leds: got %0d expected 0", leds); end
        checks++; if (pontos !== 5'd0) begin errors++; $display("FAIL reset_pontos: got %0d expected 0", pontos); end
        checks++; if (db_jogada !== 4'd0) begin errors++; $display("FAIL reset_jogada: got %0d expected 0", db_jogada); end
        checks++; if (fimS !== 1'b1) begin errors++; $display("FAIL reset_fimS: got %b expected 1", fimS); end
        checks++; if (fimJ !== 1'b0) begin errors++; $display("FAIL reset_fimJ: got %b expected 0", fimJ); end
        checks++; if (fimT !== 1'b0) begin errors++; $display("FAIL reset_fimT: got %b expected 0", fimT); end
        checks++; if (timerLedsFim !== 1'b0) begin errors++; $display("FAIL reset_timerLedsFim: got %b expected 0", timerLedsFim); end
        checks++; if (jogada_feita !== 1'b0) begin errors++; $display("FAIL reset_jogada_feita: got %b expected 0", jogada_feita); end
    endtask

    task automatic test_load_compare();
        for (int i = 0; i < 16; i++) begin
            load_we = 1; load_addr = 4'(i);
            load_data = (i == 0) ? 4'd1 : (i == 1) ? 4'd2 : (i == 2) ? 4'd4 : 4'($urandom);
            mem_m[i] = load_data;
            step();
        end
        load_we = 0;
        for (int i = 0; i < 16; i++) begin
            checks++; if (db_contagem !== 4'(c_m)) begin errors++; $display("FAIL readback_addr: got %0d expected %0d", db_contagem, c_m); end
            checks++; if (db_memoria !== mem_m[c_m]) begin errors++; $display("FAIL readback_data[%0d]: got %0d expected %0d", c_m, db_memoria, mem_m[c_m]); end
            contaC = 1; step(); contaC = 0;
            c_m = (c_m + 1) % 16;
        end
        // a write lands on the read path the following cycle
        load_we = 1; load_addr = 0; load_data = 4'd9; step();
        checks++; if (db_memoria !== 4'd9) begin errors++; $display("FAIL write_visible: got %0d expected 9", db_memoria); end
        load_data = 4'd1; step(); load_we = 0;
        checks++; if (db_memoria !== 4'd1) begin errors++; $display("FAIL write_restore: got %0d expected 1", db_memoria); end
        // compare a jogada against mem[1]
        chaves = 4'd2; registraR = 1; contaC = 1; step();
        chaves = 0; registraR = 0; contaC = 0; c_m = 1;
        checks++; if (db_jogada !== 4'd2) begin errors++; $display("FAIL jogada_reg: got %0d expected 2", db_jogada); end
        checks++; if (igual !== 1'b1) begin errors++; $display("FAIL igual_match: got %b expected 1", igual); end
        checks++; if (fimS !== 1'b0) begin errors++; $display("FAIL fimS_before: got %b expected 0", fimS); end
        contaS = 1; step(); contaS = 0; s_m = 1;
        checks++; if (fimS !== 1'b1) begin errors++; $display("FAIL fimS_after: got %b expected 1", fimS); end
        chaves = 4'd4; registraR = 1; step(); chaves = 0; registraR = 0;
        checks++; if (igual !== 1'b0) begin errors++; $display("FAIL igual_mismatch: got %b expected 0", igual); end
        zeraR = 1; step(); zeraR = 0;
        checks++; if (db_jogada !== 4'd0) begin errors++; $display("FAIL zeraR: got %0d expected 0", db_jogada); end
    endtask

    task automatic test_limite();
        zeraS = 1; step(); zeraS = 0; s_m = 0;
        limite_in = 4'd3; modo = 0; registraD = 1; step(); registraD = 0;
        checks++; if (fimJ !== 1'b0) begin errors++; $display("FAIL fimJ_start: got %b expected 0", fimJ); end
        for (int i = 0; i < 16; i++) begin
            contaS = 1; step(); contaS = 0;
            s_m = (s_m + 1) % 16;
            checks++; if (db_seqCont !== 4'(s_m)) begin errors++; $display("FAIL seqCont: got %0d expected %0d", db_seqCont, s_m); end
            checks++; if (fimJ !== (s_m == 3)) begin errors++; $display("FAIL fimJ at s=%0d: got %b expected %b", s_m, fimJ, s_m == 3); end
        end
    endtask

    task automatic test_random_gen();
        limite_in = 4'd15; modo = 1; registraD = 1; step(); registraD = 0; modo = 0;
        zeraS = 1; step(); zeraS = 0; s_m = 0;
        for (int i = 0; i < 16; i++) begin
            gera = 1; contaS = 1; load_we = 1; load_addr = 4'(s_m);
            load_data = ($urandom % 2 == 0) ? 4'hF : 4'h0;
            step();
            s_m = (s_m + 1) % 16;
        end
        gera = 0; contaS = 0; load_we = 0;
        zeraC = 1; step(); zeraC = 0; c_m = 0;
        for (int i = 0; i < 16; i++) begin
            checks++; if ($countones(db_memoria) != 1) begin errors++; $display("FAIL gera_onehot[%0d]: got %b expected one bit set", c_m, db_memoria); end
            contaC = 1; step(); contaC = 0;
            c_m = (c_m + 1) % 16;
        end
        // back in loaded mode gera is ignored and load_we is honoured
        modo = 0; registraD = 1; step(); registraD = 0;
        load_we = 1; load_addr = 0; load_data = 4'hA; step(); load_we = 0;
        mem_m[0] = 4'hA;
        gera = 1; step(); step(); step();
        load_we = 1; load_addr = 1; load_data = 4'h6; step();
        gera = 0; load_we = 0; mem_m[1] = 4'h6;
        checks++; if (db_memoria !== mem_m[0]) begin errors++; $display("FAIL gera_ignored: got %0d expected %0d", db_memoria, mem_m[0]); end
        contaC = 1; step(); contaC = 0; c_m = 1;
        checks++; if (db_memoria !== mem_m[1]) begin errors++; $display("FAIL load_modo0: got %0d expected %0d", db_memoria, mem_m[1]); end
    endtask

    task automatic test_leds();
        logic [3:0] leds_m;
        load_we = 1; load_addr = 0; load_data = 4'd8;
        zeraC = 1; zeraTLeds = 1; zeraM = 1; step();
        load_we = 0; zeraC = 0; zeraTLeds = 0; zeraM = 0;
        mem_m[0] = 4'd8; c_m = 0;
        registraM = 1; contaTLeds = 1; step(); registraM = 0;
        t_m = 1; leds_m = 4'd8;
        checks++; if (leds !== 4'd8) begin errors++; $display("FAIL leds_load: got %0d expected 8", leds); end
        for (int k = 0; k < 1002; k++) begin
            if (t_m == 500) leds_m = 4'd0;
            step();
            t_m = (t_m + 1) % 1000;
            checks++; if (leds !== leds_m) begin errors++; $display("FAIL leds_t%0d: got %0d expected %0d", t_m, leds, leds_m); end
            checks++; if (timerLedsFim !== (t_m == 999)) begin errors++; $display("FAIL timerLedsFim_t%0d: got %b expected %b", t_m, timerLedsFim, t_m == 999); end
        end
        contaTLeds = 0;
        registraM = 1; zeraM = 1; step();
        checks++; if (leds !== 4'd0) begin errors++; $display("FAIL leds_clear_beats_load: got %0d expected 0", leds); end
        zeraM = 0; step(); registraM = 0;
        checks++; if (leds !== 4'd8) begin errors++; $display("FAIL leds_reload: got %0d expected 8", leds); end
        zeraM = 1; step(); zeraM = 0;
        checks++; if (leds !== 4'd0) begin errors++; $display("FAIL leds_zeraM: got %0d expected 0", leds); end
    endtask

    task automatic test_jogada();
        logic [3:0] ch;
        bit prev_m;
        chaves = 0; step();
        chaves = 4'd4; #1;
        checks++; if (jogada_feita !== 1'b1) begin errors++; $display("FAIL feita_first: got %b expected 1", jogada_feita); end
        checks++; if (jogada_valida !== 1'b1) begin errors++; $display("FAIL valida_4: got %b expected 1", jogada_valida); end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (jogada_feita !== 1'b0) begin errors++; $display("FAIL feita_held%0d: got %b expected 0", i, jogada_feita); end
            checks++; if (jogada_valida !== 1'b1) begin errors++; $display("FAIL valida_held%0d: got %b expected 1", i, jogada_valida); end
        end
        chaves = 4'd6; #1;
        checks++; if (jogada_valida !== 1'b0) begin errors++; $display("FAIL valida_6: got %b expected 0", jogada_valida); end
        checks++; if (jogada_feita !== 1'b0) begin errors++; $display("FAIL feita_6: got %b expected 0", jogada_feita); end
        step();
        chaves = 0; step(); prev_m = 0;
        for (int i = 0; i < 40; i++) begin
            ch = 4'($urandom);
            chaves = ch; #1;
            checks++; if (jogada_feita !== ((ch != 0) && !prev_m)) begin errors++; $display("FAIL feita_rand ch=%0d: got %b expected %b", ch, jogada_feita, (ch != 0) && !prev_m); end
            checks++; if (jogada_valida !== ($countones(ch) == 1)) begin errors++; $display("FAIL valida_rand ch=%0d: got %b expected %b", ch, jogada_valida, $countones(ch) == 1); end
            prev_m = (ch != 0);
            step();
        end
        chaves = 0;
    endtask

    task automatic test_pontos();
        zeraP = 1; step(); zeraP = 0; p_m = 0;
        checks++; if (pontos !== 5'd0) begin errors++; $display("FAIL pontos_zero: got %0d expected 0", pontos); end
        incPontos = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            p_m = (p_m < 16) ? p_m + 1 : 16;
            checks++; if (pontos !== 5'(p_m)) begin errors++; $display("FAIL pontos_inc%0d: got %0d expected %0d", i, pontos, p_m); end
        end
        zeraP = 1; step(); zeraP = 0; incPontos = 0; p_m = 0;
        checks++; if (pontos !== 5'd0) begin errors++; $display("FAIL pontos_zera_priority: got %0d expected 0", pontos); end
    endtask

    task automatic run_timeout(input int cycles);
        contaT = 1;
        for (int i = 0; i < cycles; i++) begin
            step();
            t_m = (t_m + 1) % 5000;
            checks++; if (fimT !== (t_m == 4999)) begin errors++; $display("FAIL fimT_t%0d: got %b expected %b", t_m, fimT, t_m == 4999); end
        end
        contaT = 0;
    endtask

    task automatic test_timeout_and_reset();
        zeraT = 1; step(); zeraT = 0; t_m = 0;
        run_timeout(5000);
        // build up state, then reset with every strobe still asserted
        contaC = 1; contaS = 1; incPontos = 1; contaT = 1; contaTLeds = 1;
        chaves = 4'd1; registraR = 1; registraM = 1;
        step(); step(); step();
        reset = 1; step(); reset = 0;
        contaC = 0; contaS = 0; incPontos = 0; contaT = 0; contaTLeds = 0;
        registraR = 0; registraM = 0;
        t_m = 0; c_m = 0; s_m = 0;
        checks++; if (db_contagem !== 4'd0) begin errors++; $display("FAIL rst2_contC: got %0d expected 0", db_contagem); end
        checks++; if (db_seqCont !== 4'd0) begin errors++; $display("FAIL rst2_contS: got %0d expected 0", db_seqCont); end
        checks++; if (pontos !== 5'd0) begin errors++; $display("FAIL rst2_pontos: got %0d expected 0", pontos); end
        checks++; if (leds !== 4'd0) begin errors++; $display("FAIL rst2_leds: got %0d expected 0", leds); end
        checks++; if (db_jogada !== 4'd0) begin errors++; $display("FAIL rst2_jogada: got %0d expected 0", db_jogada); end
        checks++; if (fimJ !== 1'b0) begin errors++; $display("FAIL rst2_fimJ: got %b expected 0", fimJ); end
        checks++; if (fimS !== 1'b1) begin errors++; $display("FAIL rst2_fimS: got %b expected 1", fimS); end
        checks++; if (jogada_feita !== 1'b0) begin errors++; $display("FAIL rst2_feita: got %b expected 0", jogada_feita); end
        checks++; if (db_memoria !== mem_m[0]) begin errors++; $display("FAIL rst2_mem_kept: got %0d expected %0d", db_memoria, mem_m[0]); end
        chaves = 0;
        run_timeout(4999);
    endtask

    initial begin
        idle();
        repeat (2) @(posedge clock);
        #2;
        test_reset();
        test_load_compare();
        test_limite();
        test_random_gen();
        test_leds();
        test_jogada();
        test_pontos();
        test_timeout_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
